seq_bcd_7seg: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using multi-cycle double dabble (shift-add-3), with a per-digit 7-segment encoder.
- Successor to the fixed 6-bit / 2-digit combinational converter; generalised in input width, digit count and segment polarity.
- Adds a start/busy/done handshake, leading-zero blanking and overflow indication.
- Sits between counter/ALU datapaths and the board display drivers.

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_digit_to_seg.sv | 17 +
 rtl/seq_bcd_7seg.sv | 117 +++++++++++
 tb/tb_seq_bcd_7seg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, 7-segment glyphs and digit helpers for seq_bcd_7seg
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   function automatic logic [3:0] add3(input logic [3:0] d);
      return d >= 4'd5 ? d + 4'd3 : d;
   endfunction
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return SEG_0;
         4'd1: return SEG_1;
         4'd2: return SEG_2;
         4'd3: return SEG_3;
         4'd4: return SEG_4;
         4'd5: return SEG_5;
         4'd6: return SEG_6;
         4'd7: return SEG_7;
         4'd8: return SEG_8;
         4'd9: return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/bcd_digit_to_seg.sv
// bcd_digit_to_seg: one BCD digit to 7-segment pattern with blank/dash override and polarity
module bcd_digit_to_seg
   import bcd_pkg::*;
#(
   parameter int SEG_ACT_LOW = 1
) (
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);
   logic [6:0] act;
   always_comb begin
      act = dash ? SEG_DASH : blank ? SEG_BLANK : seg_of(digit);
      seg = (SEG_ACT_LOW != 0) ? ~act : act;
   end
endmodule

// File: rtl/seq_bcd_7seg.sv
// seq_bcd_7seg: multi-cycle double-dabble binary-to-BCD converter with 7-segment outputs
module seq_bcd_7seg
   import bcd_pkg::*;
#(
   parameter int BIN_W       = 6,
   parameter int DIGITS      = 2,
   parameter int BLANK_LZ    = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_start,
   input  logic [BIN_W-1:0]      in_Bin,
   output logic                  out_busy,
   output logic                  out_done,
   output logic                  out_ovf,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic [7*DIGITS-1:0]   out_seg
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);
   localparam logic [6:0] BLANK_OUT = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   state_t              state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [BW-1:0]       acc_q, acc_d, adj;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                sticky_q, sticky_d;
   logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [7*DIGITS-1:0] seg_q, seg_d, seg_w;
   logic [DIGITS-1:0]   blank;
   always_comb begin
      logic any;
      any = 1'b0;
      adj = acc_q;
      blank = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         any = any | (|acc_q[4*k +: 4]);
         blank[k] = (BLANK_LZ != 0) && (k != 0) && !any;
         adj[4*k +: 4] = add3(acc_q[4*k +: 4]);
      end
   end
   for (genvar i = 0; i < DIGITS; i++) begin : g_seg
      bcd_digit_to_seg #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg (
         .digit (acc_q[4*i +: 4]),
         .blank (blank[i]),
         .dash  (sticky_q),
         .seg   (seg_w[7*i +: 7])
      );
   end
   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      busy_d   = done_q ? 1'b0 : busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      bcd_d    = bcd_q;
      seg_d    = seg_q;
      case (state_q)
         IDLE: if (in_start) begin
            state_d  = SHIFT;
            bin_d    = in_Bin;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            busy_d   = 1'b1;
         end
         SHIFT: begin
            {acc_d, bin_d} = {adj, bin_q} << 1;
            sticky_d = sticky_q | adj[BW-1];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(BIN_W - 1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
            ovf_d   = sticky_q;
            bcd_d   = sticky_q ? '1 : acc_q;
            seg_d   = seg_w;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         bcd_q    <= '0;
         seg_q    <= {DIGITS{BLANK_OUT}};
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         bcd_q    <= bcd_d;
         seg_q    <= seg_d;
      end
   end
   assign out_busy = busy_q;
   assign out_done = done_q;
   assign out_ovf  = ovf_q;
   assign out_bcd  = bcd_q;
   assign out_seg  = seg_q;
endmodule

// File: tb/tb_seq_bcd_7seg.sv
// tb_seq_bcd_7seg: scoreboard bench over four parameter sets against a decimal reference model
module tb_seq_bcd_7seg;
   localparam int N = 4;
   localparam int PBW [N] = '{6, 7, 10, 1};
   localparam int PD  [N] = '{2, 2, 3, 1};
   localparam int PBL [N] = '{1, 1, 0, 1};
   localparam int PSA [N] = '{1, 1, 0, 1};
   localparam logic [6:0] TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   typedef struct {
      logic        ovf;
      logic [39:0] bcd;
      logic [69:0] seg;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start [N];
   logic [31:0] bin [N];
   logic        busy [N], done [N], ovf [N];
   logic [39:0] bcd_w [N];
   logic [69:0] seg_w [N];
   exp_t        sb [N][$];
   logic [39:0] last [N];
   int          issued [N], done_cnt [N];
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   function automatic exp_t model(longint v, int d, int blz, int sal);
      exp_t e;
      longint p = 1;
      longint lim = 1;
      logic [6:0] s;
      int dig;
      for (int k = 0; k < d; k++) lim = lim * 10;
      e.ovf = v >= lim;
      e.bcd = '0;
      e.seg = '0;
      for (int k = 0; k < d; k++) begin
         dig = int'((v / p) % 10);
         e.bcd[4*k +: 4] = e.ovf ? 4'hF : 4'(dig);
         s = e.ovf ? 7'h40 : (blz != 0 && k > 0 && v < p) ? 7'h00 : TAB[dig];
         e.seg[7*k +: 7] = (sal != 0) ? ~s : s;
         p = p * 10;
      end
      return e;
   endfunction
   task automatic chk(input string name, input int i, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %h expected %h", name, i, act, exp);
      end
   endtask
   for (genvar i = 0; i < N; i++) begin : g
      logic [4*PD[i]-1:0] b;
      logic [7*PD[i]-1:0] s;
      exp_t e;
      seq_bcd_7seg #(.BIN_W(PBW[i]), .DIGITS(PD[i]), .BLANK_LZ(PBL[i]), .SEG_ACT_LOW(PSA[i])) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_start (start[i]),
         .in_Bin   (bin[i][PBW[i]-1:0]),
         .out_busy (busy[i]),
         .out_done (done[i]),
         .out_ovf  (ovf[i]),
         .out_bcd  (b),
         .out_seg  (s)
      );
      assign bcd_w[i] = 40'(b);
      assign seg_w[i] = 70'(s);
      always @(negedge clk) if (done[i]) begin
         done_cnt[i]++;
         if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d got bcd %h expected no done", i, bcd_w[i]);
         end else begin
            e = sb[i].pop_front();
            chk("bcd", i, 70'(bcd_w[i]), 70'(e.bcd));
            chk("seg", i, seg_w[i], e.seg);
            chk("ovf", i, 70'(ovf[i]), 70'(e.ovf));
         end
      end
   end
   task automatic conv(input int i, input longint v, input int poke = -1);
      exp_t e;
      int k;
      e = model(v, PD[i], PBL[i], PSA[i]);
      bin[i] = 32'(v);
      start[i] = 1'b1;
      sb[i].push_back(e);
      issued[i]++;
      @(negedge clk);
      k = 1;
      bin[i] = $urandom;
      start[i] = 1'b0;
      chk("busy_after_start", i, 70'(busy[i]), 70'(1));
      chk("hold_prev", i, 70'(bcd_w[i]), 70'(last[i]));
      while (!done[i] && k < 200) begin
         start[i] = (k == poke);
         if (k == poke) bin[i] = 32'd10;
         @(negedge clk);
         k++;
      end
      start[i] = 1'b0;
      chk("latency", i, 70'(k), 70'(PBW[i] + 2));
      chk("busy_in_done", i, 70'(busy[i]), 70'(1));
      last[i] = e.bcd;
   endtask
   task automatic chk_reset(input int i);
      chk("rst_busy", i, 70'(busy[i]), 70'(0));
      chk("rst_done", i, 70'(done[i]), 70'(0));
      chk("rst_ovf", i, 70'(ovf[i]), 70'(0));
      chk("rst_bcd", i, 70'(bcd_w[i]), 70'(0));
      chk("rst_seg", i, seg_w[i], (PSA[i] != 0) ? (70'(1) << (7 * PD[i])) - 70'(1) : 70'(0));
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < N; i++) begin
         start[i] = 1'b0;
         bin[i] = '0;
         last[i] = '0;
         issued[i] = 0;
         done_cnt[i] = 0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) chk_reset(i);
      rst_n = 1'b1;
      @(negedge clk);
      conv(0, 23);
      conv(0, 41);
      conv(0, 0);
      conv(0, 59);
      conv(0, 63);
      conv(0, 23, 3);
      repeat (12) @(negedge clk);
      chk("single_done", 0, 70'(done_cnt[0]), 70'(issued[0]));
      conv(1, 100);
      conv(1, 99);
      conv(1, 127);
      conv(2, 7);
      conv(2, 999);
      conv(2, 1000);
      conv(2, 1023);
      conv(3, 0);
      conv(3, 1);
      bin[0] = 32'd50;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset(0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) last[i] = '0;
      repeat (12) @(negedge clk);
      chk("no_done_after_abort", 0, 70'(done_cnt[0]), 70'(issued[0]));
      conv(0, 5);
      for (int r = 0; r < 10; r++)
         for (int i = 0; i < N; i++)
            conv(i, longint'($urandom_range(0, (1 << PBW[i]) - 1)));
      repeat (12) @(negedge clk);
      for (int i = 0; i < N; i++) chk("done_count", i, 70'(done_cnt[i]), 70'(issued[i]));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
